// File: rtl/gf_mul_seq.sv
// ============================================================================
// Module   : gf_mul_seq
// Brief    : Multi-lane, bit-serial GF(2^WIDTH) multiplier with valid/ready
//            handshakes on the operand and result sides. All lanes share one
//            control FSM. Each product is reduced modulo POLY.
// Options  : GF_MUL_EARLY_EXIT_EN - end RUN as soon as every lane's shifted
//            multiplier is zero. The product value is the same either way.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mul_seq #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH:0] POLY  = 9'h11B,
  parameter int             LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_a,
  input  logic [LANES*WIDTH-1:0] i_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_result,
  output logic                   o_busy
);

  // Widths and constants.
  localparam int                DW   = LANES * WIDTH;
  localparam int                CW   = $clog2(WIDTH + 1);
  // Only the low WIDTH bits of POLY take part in reduction; the top bit is
  // the implicit x^WIDTH term that shifting out of the operand cancels.
  localparam logic [WIDTH-1:0]  RED  = POLY[WIDTH-1:0];
  // The RUN edge that sees this counter value performs iteration WIDTH.
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  // FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // State and datapath registers.
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] a_q,     a_d;
  logic [DW-1:0] b_q,     b_d;
  logic [DW-1:0] acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;

  // One shift-and-add step for every lane, computed in parallel.
  logic [DW-1:0] acc_step;
  logic [DW-1:0] a_step;
  logic [DW-1:0] b_step;

  // Each lane is an independent slice: nothing crosses a lane boundary.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic [WIDTH-1:0] acc_l;

    assign a_l   = a_q[k*WIDTH +: WIDTH];
    assign b_l   = b_q[k*WIDTH +: WIDTH];
    assign acc_l = acc_q[k*WIDTH +: WIDTH];

    // Conditional carry-free add of the current multiplicand.
    assign acc_step[k*WIDTH +: WIDTH] = acc_l ^ (b_l[0] ? a_l : '0);
    // xtime: multiply by x, folding the overflow back in with the polynomial.
    assign a_step[k*WIDTH +: WIDTH]   = {a_l[WIDTH-2:0], 1'b0}
                                        ^ (a_l[WIDTH-1] ? RED : '0);
    // Consume one multiplier bit per iteration, LSB first.
    assign b_step[k*WIDTH +: WIDTH]   = {1'b0, b_l[WIDTH-1:1]};
  end

`ifdef GF_MUL_EARLY_EXIT_EN
  // Nothing left to add once all remaining multiplier bits are zero.
  logic b_step_zero;
  logic ib_zero;
  assign b_step_zero = (b_step == '0);
  assign ib_zero     = (i_b == '0);
`endif

  // State register and datapath flops; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
`ifdef GF_MUL_EARLY_EXIT_EN
          // An all-zero multiplier needs no iterations: the product is 0.
          state_d = ib_zero ? S_DONE : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
`ifdef GF_MUL_EARLY_EXIT_EN
        if ((cnt_q == LAST) || b_step_zero) begin
          state_d = S_DONE;
        end
`else
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        // Result held until the consumer takes it; new operands wait in IDLE.
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load on accept, iterate in RUN, hold otherwise.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d   = i_a;
          b_d   = i_b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_RUN: begin
        a_d   = a_step;
        b_d   = b_step;
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
    endcase
    // Registered busy flag tracks the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  // Output decode from the current state.
  always_comb begin
    o_ready  = (state_q == S_IDLE);
    o_valid  = (state_q == S_DONE);
    o_result = acc_q;
    o_busy   = busy_q;
  end

endmodule

`default_nettype wire

// File: doc/gf_mul_seq.md
# gf_mul_seq

Parametrised, multi-lane, bit-serial GF(2^WIDTH) multiplier with valid/ready handshakes on both sides. It is the general-purpose successor to the fixed 8-bit AES field multiplier. It sits between the AES datapath controllers (MixColumns, key-schedule Rcon, S-box inversion) and any other GF arithmetic consumer. Each accepted operation computes LANES independent products that share one control FSM, reduced modulo POLY.

## Interface
- WIDTH, 8, field degree; operand and result width per lane (2..16).
- POLY, 9'h11B, irreducible polynomial, WIDTH+1 bits; bit WIDTH must be 1 and only bits [WIDTH-1:0] are used for reduction.
- LANES, 1, number of parallel multiplications per operation (1..16).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand set valid.
- o_ready  output  1  block can accept operands (state IDLE).
- i_a  input  LANES*WIDTH  multiplicand; lane k is i_a[k*WIDTH +: WIDTH].
- i_b  input  LANES*WIDTH  multiplier; same packing.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  LANES*WIDTH  products; same packing.
- o_busy  output  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE: o_ready=1. When i_valid=1 at a rising edge, the block latches a_reg<=i_a and b_reg<=i_b, clears acc and the iteration counter, and moves to RUN.
- RUN, per edge and per lane: if b_reg[0], then acc ^= a_reg. Then a_reg <= xtime(a_reg) and b_reg <= b_reg >> 1. The counter increments.
- xtime(x) = (x << 1) truncated to WIDTH bits, XOR POLY[WIDTH-1:0] if x[WIDTH-1] was 1.
- RUN to DONE: on the edge that performs iteration number WIDTH. The counter is $clog2(WIDTH+1) bits.
- DONE: o_valid=1 and o_result=acc, both held stable until i_ready=1 at an edge. On that edge the block returns to IDLE and o_valid drops.
- o_ready=0 in RUN and DONE. i_valid is ignored there, so there is no back-to-back accept from DONE.
- Reset asserted mid-operation aborts immediately. No o_valid is produced and the operands are discarded.
- All XOR arithmetic is carry-free. No lane ever interacts with another lane.

## Timing
- Reset values: o_ready=1 (IDLE), o_valid=0, o_busy=0, o_result=0. Internal a_reg, b_reg, acc and the counter are all 0.
- Accept at edge E0. Iterations occur at E1..E_WIDTH. o_valid is high in the cycle after E_WIDTH, so latency is WIDTH+1 edges from accept to o_valid.
- Minimum throughput: one operation per WIDTH+2 cycles when i_ready is tied 1. o_ready is high for one cycle before the next accept.
- i_ready may be held low indefinitely. o_result must not change while o_valid=1.
- o_busy is registered, and equals (state != IDLE).

## Configuration
- GF_MUL_EARLY_EXIT_EN.
- Defined: RUN ends on the edge where the shifted b_reg of every lane becomes zero, or at WIDTH iterations, whichever comes first.
  - If all lanes of i_b are 0 at accept, the block goes directly IDLE to DONE with result 0. Latency is 1 edge.
  - Otherwise latency is (highest set bit index across all lanes of i_b) + 2 edges.
- Undefined: latency is always exactly WIDTH+1 edges.
- The result value is identical with and without the macro.

## Test plan
- WIDTH=8, POLY=9'h11B, LANES=1; a=8'h57, b=8'h83, i_ready=1 → o_result=8'hC1. o_valid rises 9 edges after accept (without the macro).
- LANES=2; i_a={8'h02,8'h57}, i_b={8'h87,8'h13} → o_result={8'h15,8'hFE} in the same cycle.
- WIDTH=4, POLY=5'h13; a=4'h3, b=4'h7 → 4'h9. Also a=4'hF, b=4'h0 → 4'h0.
- Hold i_ready=0 for 20 cycles after o_valid, driving i_valid=1 with new operands throughout → o_result stays stable, o_ready stays 0, and only the first operation completes.
- Assert rst_n=0 at iteration 4, then release → o_valid never rises for the aborted operation. Outputs read their reset values. A fresh a=8'h57, b=8'h83 then yields 8'hC1.
- With GF_MUL_EARLY_EXIT_EN defined: b=8'h01 → o_valid after 2 edges, result=a. b=8'h00 → o_valid after 1 edge, result 0. b=8'h83 → 9 edges.
